serial_priority_encoder: RTL and testbench
==========================================

Name: serial_priority_encoder

Overview:
- Encoder-direction counterpart of the team's combinational binary-to-value case decoders.
- Accepts a multi-hot request vector with a valid/ready handshake.
- Emits the binary index of every set bit, lowest index first, one index per accepted output beat.
- Sits between request-generating logic and any downstream decoder that consumes 2-bit codes.

Parameters:
- N, default 4: width of the request vector; legal values are powers of 2, minimum 2.
- W, default $clog2(N): width of the emitted index; derived, not overridden.

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  synchronous reset, active-high
- in_vec  input  N  request vector
- in_valid  input  1  in_vec is valid this cycle
- in_ready  output  1  block can accept a new vector (high only in IDLE)
- out_code  output  W  binary index of the current lowest set bit
- out_valid  output  1  out_code is valid
- out_ready  input  1  downstream accepts out_code
- out_last  output  1  current beat is the final set bit of the captured vector
- zero_err  output  1  one-cycle pulse: an all-zero vector was accepted

Behaviour:
- Interface decision: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values:
  - state = IDLE, pend = 0
  - in_ready = 1, out_valid = 0, out_code = 0, out_last = 0, zero_err = 0
- States: IDLE, EMIT.
- IDLE:
  - in_ready = 1, out_valid = 0.
  - On in_valid with in_vec != 0: pend <= in_vec; go to EMIT.
  - On in_valid with in_vec == 0: stay in IDLE; zero_err = 1 for the next cycle only; nothing is emitted.
- EMIT:
  - in_ready = 0, out_valid = 1.
  - out_code = index of the lowest set bit of pend; combinational from the pend register.
  - out_last = 1 when pend has exactly one bit set.
  - On out_ready: clear that bit in pend. If out_last, go to IDLE.
  - Without out_ready: hold pend, out_code and out_last stable; no bit is dropped.
- Latency: first code is valid the cycle after acceptance. Each further code follows 1 cycle after each handshake. A k-bit vector completes in k handshakes.
- Back-to-back: the cycle after the last handshake is IDLE with in_ready = 1. There is no same-cycle re-accept; minimum vector period is k+1 cycles.
- Input ignored while in_ready = 0. A new vector is never merged into pend.
- Reset mid-EMIT: pend is discarded; the next cycle is the reset state.
- Priority: rst overrides all other inputs.
- Index arithmetic: unsigned, W bits. For N = 4, bit 3 yields 2'b11; there is no wrap.

Optional Feature:
- Macro: SPE_COUNT_EN.
- When defined, adds port `out_count  output  W+1`. It holds the population count of the vector captured at acceptance.
  - Constant for the whole EMIT period.
  - 0 in IDLE and after reset.
  - Must equal the number of beats emitted.
- When undefined, the port and its register are absent; all other behaviour is identical.

Decomposition:
- Package `spe_pkg`:
  - state enum {IDLE, EMIT}
  - localparam helpers for W from N
- Sub-module `lowest_set_index`: purely combinational. Takes an N-bit vector; returns the W-bit index of the lowest set bit and a single-bit flag (exactly one bit set). Instantiated once on pend.

Test Plan:
- Reset then idle: rst=1 for 2 cycles → in_ready=1, out_valid=0, out_code=0, zero_err=0.
- Multi-hot, ready held high: in_vec=4'b1011 accepted → out_code 0,1,3 on consecutive cycles; out_last=1 only on code 3; in_ready=1 on the following cycle.
- Backpressure: in_vec=4'b0110, out_ready low for 3 cycles → out_code holds 1 with out_valid=1; then out_ready=1 → 1, 2; out_last on 2.
- Zero vector: in_vec=0, in_valid=1 → zero_err pulses for exactly 1 cycle; out_valid never asserts; in_ready stays 1.
- Ignored input and mid-op reset: accept 4'b1111; assert in_valid with 4'b0001 during EMIT → ignored. After 2 beats, rst=1 → next cycle IDLE, out_valid=0, pend cleared.
- SPE_COUNT_EN build: in_vec=4'b1101 → out_count=3 throughout EMIT, exactly 3 beats emitted; out_count=0 after return to IDLE.

Source files
------------

// File: rtl/spe_pkg.sv
// rtl/spe_pkg.sv - shared state encoding and width helpers for the serial priority encoder
package spe_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } spe_state_t;

    localparam int SPE_DEFAULT_N = 4;

    // Index width for an N-bit request vector; N is a power of two, at least 2.
    function automatic int spe_idx_width(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/serial_priority_encoder_lowest_set_index.sv
// rtl/serial_priority_encoder_lowest_set_index.sv - combinational lowest-set-bit index and single-bit flag
module lowest_set_index
    import spe_pkg::*;
#(
    parameter int N = SPE_DEFAULT_N,
    localparam int W = spe_idx_width(N)
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx,
    output logic         onehot
);

    logic [N-1:0] vec_minus_one;

    assign vec_minus_one = vec - N'(1);
    // Clearing the lowest set bit leaves zero only when exactly one bit was set.
    assign onehot        = (vec != '0) && ((vec & vec_minus_one) == '0);

    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = W'(i);
            end
        end
    end

endmodule

// File: rtl/serial_priority_encoder.sv
// rtl/serial_priority_encoder.sv - emits the index of each set request bit, lowest first, one per beat
// Optional population-count output enabled by SPE_COUNT_EN.
module serial_priority_encoder
    import spe_pkg::*;
#(
    parameter int N = SPE_DEFAULT_N,
    localparam int W = spe_idx_width(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] in_vec,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_code,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_last,
    output logic         zero_err
`ifdef SPE_COUNT_EN
    ,
    output logic [W:0]   out_count
`endif
);

    spe_state_t   state;
    logic [N-1:0] pend;
    logic [N-1:0] pend_minus_one;
    logic [W-1:0] low_idx;
    logic         low_onehot;

    lowest_set_index #(
        .N (N)
    ) u_lowest (
        .vec    (pend),
        .idx    (low_idx),
        .onehot (low_onehot)
    );

    // pend is cleared in IDLE, so both outputs read zero there without extra gating.
    assign out_code       = low_idx;
    assign out_last       = low_onehot;
    assign pend_minus_one = pend - N'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pend      <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            zero_err  <= 1'b0;
        end else begin
            zero_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (in_vec != '0) begin
                            pend      <= in_vec;
                            state     <= EMIT;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                        end else begin
                            zero_err <= 1'b1;
                        end
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        pend <= pend & pend_minus_one;
                        if (low_onehot) begin
                            state     <= IDLE;
                            in_ready  <= 1'b1;
                            out_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    pend      <= '0;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef SPE_COUNT_EN
    logic [W:0] in_popcount;

    always_comb begin
        in_popcount = '0;
        for (int i = 0; i < N; i++) begin
            in_popcount = in_popcount + (W + 1)'(in_vec[i]);
        end
    end

    // Latched at acceptance and held for the whole EMIT period.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_count <= '0;
        end else if (state == IDLE) begin
            if (in_valid && (in_vec != '0)) begin
                out_count <= in_popcount;
            end
        end else if (out_ready && low_onehot) begin
            out_count <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_serial_priority_encoder.sv
// tb/tb_serial_priority_encoder.sv - directed self-checking bench for serial_priority_encoder
module tb_serial_priority_encoder;

    logic       clk;
    logic       rst;
    logic [3:0] in_vec;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] out_code;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
    logic       zero_err;
`ifdef SPE_COUNT_EN
    logic [2:0] out_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    serial_priority_encoder #(
        .N (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_vec    (in_vec),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_code  (out_code),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .zero_err  (zero_err)
`ifdef SPE_COUNT_EN
        ,
        .out_count (out_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_beat(input string tag, input logic [1:0] code, input logic last);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_code"},  32'(out_code), 32'(code));
        check({tag, "_last"},  32'(out_last), 32'(last));
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_ready"}, 32'(in_ready),  32'd1);
        check({tag, "_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_code"},  32'(out_code),  32'd0);
        check({tag, "_last"},  32'(out_last),  32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        in_vec    = 4'b0000;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check_idle("rst");
        check("rst_zero_err", 32'(zero_err), 32'd0);
`ifdef SPE_COUNT_EN
        check("rst_count", 32'(out_count), 32'd0);
`endif

        // 1011 with downstream always ready: codes 0,1,3
        in_vec    = 4'b1011;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check_beat("mh0", 2'd0, 1'b0);
        tick();
        check_beat("mh1", 2'd1, 1'b0);
        tick();
        check_beat("mh3", 2'd3, 1'b1);
        tick();
        check_idle("mh_done");

        // 0110 with three stalled cycles
        in_vec    = 4'b0110;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_beat("bp_hold", 2'd1, 1'b0);
            tick();
        end
        out_ready = 1'b1;
        check_beat("bp1", 2'd1, 1'b0);
        tick();
        check_beat("bp2", 2'd2, 1'b1);
        tick();
        check_idle("bp_done");

        // All-zero vector: single-cycle error pulse, nothing emitted
        in_vec   = 4'b0000;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("zero_pulse", 32'(zero_err), 32'd1);
        check_idle("zero_a");
        tick();
        check("zero_clear", 32'(zero_err), 32'd0);
        check_idle("zero_b");

        // 1111, new vector offered mid-EMIT is ignored, then reset after two beats
        in_vec   = 4'b1111;
        in_valid = 1'b1;
        tick();
        in_vec   = 4'b0001;
        check_beat("ig0", 2'd0, 1'b0);
        tick();
        check_beat("ig1", 2'd1, 1'b0);
        tick();
        check_beat("ig2", 2'd2, 1'b0);
        rst      = 1'b1;
        in_valid = 1'b0;
        tick();
        rst = 1'b0;
        check_idle("midrst");
        check("midrst_zero_err", 32'(zero_err), 32'd0);
        tick();
        check_idle("midrst_stay");

        // 1101: three beats 0,2,3 with constant population count
        in_vec   = 4'b1101;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check_beat("pc0", 2'd0, 1'b0);
`ifdef SPE_COUNT_EN
        check("pc0_count", 32'(out_count), 32'd3);
`endif
        tick();
        check_beat("pc2", 2'd2, 1'b0);
`ifdef SPE_COUNT_EN
        check("pc2_count", 32'(out_count), 32'd3);
`endif
        tick();
        check_beat("pc3", 2'd3, 1'b1);
`ifdef SPE_COUNT_EN
        check("pc3_count", 32'(out_count), 32'd3);
`endif
        tick();
        check_idle("pc_done");
`ifdef SPE_COUNT_EN
        check("pc_done_count", 32'(out_count), 32'd0);
`endif

        // Single highest bit: first beat is also last, code 3 without wrap
        in_vec   = 4'b1000;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check_beat("hi", 2'd3, 1'b1);
        tick();
        check_idle("hi_done");

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
